// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the two-master round-robin
// Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_ADR_W  = 32;
    localparam int WB_DAT_W  = 32;
    localparam int WB_SEL_W  = 4;
    localparam int TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1
    } state_e;

    typedef struct packed {
        logic                cyc;
        logic                stb;
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

    // A master's request only counts while its cycle is open.
    function automatic wb_req_t gate_req(wb_req_t r);
        gate_req = r.cyc ? r : '0;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// One Wishbone link: master drives the request side,
// slave drives read data and the response.
interface wb_arbiter_rr_if;
    import wb_arb_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat_w;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat_r;
    logic                ack;
    logic                err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_arb_timeout.sv
// Watchdog for a granted strobe: flags the cycle in which
// the wait has reached the limit without any response.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic resp,
    input  logic clear,
    output logic timeout
);

    localparam logic [TMO_CNT_W-1:0] LIMIT =
        TMO_CNT_W'(TIMEOUT_CYCLES);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    assign timeout = active && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!active || resp || clear || timeout) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Two-master round-robin Wishbone arbiter with a registered
// grant and a stuck-strobe timeout.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                s0_wb_cyc_i,
    input  logic                s0_wb_stb_i,
    input  logic                s0_wb_we_i,
    input  logic [WB_ADR_W-1:0] s0_wb_adr_i,
    input  logic [WB_DAT_W-1:0] s0_wb_dat_i,
    input  logic [WB_SEL_W-1:0] s0_wb_sel_i,
    output logic [WB_DAT_W-1:0] s0_wb_dat_o,
    output logic                s0_wb_ack_o,
    output logic                s0_wb_err_o,
    input  logic                s1_wb_cyc_i,
    input  logic                s1_wb_stb_i,
    input  logic                s1_wb_we_i,
    input  logic [WB_ADR_W-1:0] s1_wb_adr_i,
    input  logic [WB_DAT_W-1:0] s1_wb_dat_i,
    input  logic [WB_SEL_W-1:0] s1_wb_sel_i,
    output logic [WB_DAT_W-1:0] s1_wb_dat_o,
    output logic                s1_wb_ack_o,
    output logic                s1_wb_err_o,
    output logic                m_wb_cyc_o,
    output logic                m_wb_stb_o,
    output logic                m_wb_we_o,
    output logic [WB_ADR_W-1:0] m_wb_adr_o,
    output logic [WB_DAT_W-1:0] m_wb_dat_o,
    output logic [WB_SEL_W-1:0] m_wb_sel_o,
    input  logic [WB_DAT_W-1:0] m_wb_dat_i,
    input  logic                m_wb_ack_i,
    input  logic                m_wb_err_i,
    output logic [1:0]          o_grant,
    output logic                o_timeout
);

    state_e  state_q, state_d;
    logic    last_served_q, last_served_d;
    wb_req_t req0, req1, own;
    logic    tmo, rsp_ack, rsp_err;

    always_comb begin
        req0 = '{cyc: s0_wb_cyc_i, stb: s0_wb_stb_i,
                 we: s0_wb_we_i, adr: s0_wb_adr_i,
                 dat: s0_wb_dat_i, sel: s0_wb_sel_i};
        req1 = '{cyc: s1_wb_cyc_i, stb: s1_wb_stb_i,
                 we: s1_wb_we_i, adr: s1_wb_adr_i,
                 dat: s1_wb_dat_i, sel: s1_wb_sel_i};
    end

    // On a tie the master that was not served last wins.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0.cyc && req1.cyc) begin
                    state_d = last_served_q ? ST_OWN0 : ST_OWN1;
                end else if (req0.cyc) begin
                    state_d = ST_OWN0;
                end else if (req1.cyc) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0.cyc) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!req1.cyc) begin
                    state_d       = ST_IDLE;
                    last_served_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    always_comb begin
        own = '0;
        if (state_q == ST_OWN0) begin
            own = gate_req(req0);
        end else if (state_q == ST_OWN1) begin
            own = gate_req(req1);
        end
    end

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_resetn),
        .active  (own.stb),
        .resp    (own.stb & (m_wb_ack_i | m_wb_err_i)),
        .clear   (state_d != state_q),
        .timeout (tmo)
    );

    // Error wins over a simultaneous ack.
    assign rsp_err = own.stb & m_wb_err_i;
    assign rsp_ack = own.stb & m_wb_ack_i & ~m_wb_err_i & ~tmo;

    always_comb begin
        m_wb_cyc_o  = own.cyc;
        m_wb_stb_o  = own.stb & ~tmo;
        m_wb_we_o   = own.we;
        m_wb_adr_o  = own.adr;
        m_wb_dat_o  = own.dat;
        m_wb_sel_o  = own.sel;
        s0_wb_dat_o = '0;
        s0_wb_ack_o = 1'b0;
        s0_wb_err_o = 1'b0;
        s1_wb_dat_o = '0;
        s1_wb_ack_o = 1'b0;
        s1_wb_err_o = 1'b0;
        if (state_q == ST_OWN0) begin
            s0_wb_dat_o = own.cyc ? m_wb_dat_i : '0;
            s0_wb_ack_o = rsp_ack;
            s0_wb_err_o = rsp_err | tmo;
        end else if (state_q == ST_OWN1) begin
            s1_wb_dat_o = own.cyc ? m_wb_dat_i : '0;
            s1_wb_ack_o = rsp_ack;
            s1_wb_err_o = rsp_err | tmo;
        end
    end

    assign o_grant   = {state_q == ST_OWN1, state_q == ST_OWN0};
    assign o_timeout = tmo;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: a response scoreboard
// plus per-step checks of grant, bus mux and timeout.
module tb_wb_arbiter_rr;

    typedef struct {
        logic [1:0]  src;
        logic        err;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant;
    logic       tmo;
    exp_t       exp_q[$];
    int         n_assert = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    wb_arbiter_rr_if s0_if ();
    wb_arbiter_rr_if s1_if ();
    wb_arbiter_rr_if m_if ();

    wb_arbiter_rr #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk       (clk),
        .i_resetn    (rst_n),
        .s0_wb_cyc_i (s0_if.cyc),
        .s0_wb_stb_i (s0_if.stb),
        .s0_wb_we_i  (s0_if.we),
        .s0_wb_adr_i (s0_if.adr),
        .s0_wb_dat_i (s0_if.dat_w),
        .s0_wb_sel_i (s0_if.sel),
        .s0_wb_dat_o (s0_if.dat_r),
        .s0_wb_ack_o (s0_if.ack),
        .s0_wb_err_o (s0_if.err),
        .s1_wb_cyc_i (s1_if.cyc),
        .s1_wb_stb_i (s1_if.stb),
        .s1_wb_we_i  (s1_if.we),
        .s1_wb_adr_i (s1_if.adr),
        .s1_wb_dat_i (s1_if.dat_w),
        .s1_wb_sel_i (s1_if.sel),
        .s1_wb_dat_o (s1_if.dat_r),
        .s1_wb_ack_o (s1_if.ack),
        .s1_wb_err_o (s1_if.err),
        .m_wb_cyc_o  (m_if.cyc),
        .m_wb_stb_o  (m_if.stb),
        .m_wb_we_o   (m_if.we),
        .m_wb_adr_o  (m_if.adr),
        .m_wb_dat_o  (m_if.dat_w),
        .m_wb_sel_o  (m_if.sel),
        .m_wb_dat_i  (m_if.dat_r),
        .m_wb_ack_i  (m_if.ack),
        .m_wb_err_i  (m_if.err),
        .o_grant     (grant),
        .o_timeout   (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic err,
                        input logic cd, input logic [31:0] dat);
        exp_t e;
        e.src = src;
        e.err = err;
        e.chk_dat = cd;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Pop one expected response for every response the DUT gives.
    task automatic mon();
        logic [1:0]  got;
        logic        gerr;
        logic [31:0] gdat;
        exp_t        e;
        got = {s1_if.ack | s1_if.err, s0_if.ack | s0_if.err};
        gerr = got[1] ? s1_if.err : s0_if.err;
        gdat = got[1] ? s1_if.dat_r : s0_if.dat_r;
        if (got != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(got), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_src", 32'(got), 32'(e.src));
                chk("resp_err", 32'(gerr), 32'(e.err));
                if (e.chk_dat) chk("resp_dat", gdat, e.dat);
            end
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic ev();
        #1;
        mon();
    endtask

    task automatic mst(input int n, input logic c, input logic s,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        if (n == 0) begin
            s0_if.cyc = c; s0_if.stb = s; s0_if.we = w;
            s0_if.adr = a; s0_if.dat_w = d; s0_if.sel = 4'hF;
        end else begin
            s1_if.cyc = c; s1_if.stb = s; s1_if.we = w;
            s1_if.adr = a; s1_if.dat_w = d; s1_if.sel = 4'hF;
        end
    endtask

    task automatic slv(input logic a, input logic e,
                       input logic [31:0] d);
        m_if.ack = a;
        m_if.err = e;
        m_if.dat_r = d;
    endtask

    task automatic pulse_reset();
        nxt();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mst(0, 0, 0, 0, 0, 0);
        mst(1, 0, 0, 0, 0, 0);
        slv(0, 0, 0);
        #12;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_mcyc", 32'(m_if.cyc), 32'h0);
        chk("rst_mstb", 32'(m_if.stb), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        rst_n = 1'b1;

        // single s0 write, slave acks 3 cycles after strobe
        nxt();
        mst(0, 1, 1, 1, 32'h11223344, 32'h55667788);
        push(2'b01, 0, 0, 0);
        ev();
        chk("a_grant_pre", 32'(grant), 32'h0);
        nxt();
        m_if.dat_r = 32'hDEADBEEF;
        ev();
        chk("a_grant", 32'(grant), 32'h1);
        chk("a_adr", m_if.adr, 32'h11223344);
        chk("a_dat", m_if.dat_w, 32'h55667788);
        chk("a_we", 32'(m_if.we), 32'h1);
        chk("a_sel", 32'(m_if.sel), 32'hF);
        chk("a_stb", 32'(m_if.stb), 32'h1);
        chk("a_s1_dat", s1_if.dat_r, 32'h0);
        repeat (2) begin nxt(); ev(); end
        nxt();
        slv(1, 0, 0);
        ev();
        chk("a_ack", 32'(s0_if.ack), 32'h1);
        nxt();
        mst(0, 0, 0, 0, 0, 0);
        slv(0, 0, 0);
        ev();
        chk("a_ack_once", 32'(s0_if.ack), 32'h0);
        chk("a_grant_hold", 32'(grant), 32'h1);
        nxt();
        slv(1, 0, 32'h12345678);
        ev();
        chk("a_idle", 32'(grant), 32'h0);
        chk("idle_resp_drop", 32'(s0_if.ack), 32'h0);
        chk("idle_mcyc", 32'(m_if.cyc), 32'h0);
        slv(0, 0, 0);

        // tie after reset: s0, s1, s0 with an idle gap between owners
        pulse_reset();
        nxt();
        mst(0, 1, 1, 1, 32'h100, 32'h1);
        mst(1, 1, 1, 1, 32'h200, 32'h2);
        push(2'b01, 0, 0, 0);
        push(2'b10, 0, 0, 0);
        ev();
        chk("b_g0", 32'(grant), 32'h0);
        nxt(); slv(1, 0, 0); ev();
        chk("b_g1", 32'(grant), 32'h1);
        nxt(); mst(0, 0, 0, 0, 0, 0); slv(0, 0, 0); ev();
        chk("b_g2", 32'(grant), 32'h1);
        chk("b_mcyc_drop", 32'(m_if.cyc), 32'h0);
        nxt(); mst(0, 1, 1, 1, 32'h100, 32'h3);
        push(2'b01, 0, 0, 0);
        ev();
        chk("b_g3", 32'(grant), 32'h0);
        nxt(); slv(1, 0, 0); ev();
        chk("b_g4", 32'(grant), 32'h2);
        chk("b_adr4", m_if.adr, 32'h200);
        nxt(); mst(1, 0, 0, 0, 0, 0); slv(0, 0, 0); ev();
        nxt(); ev();
        chk("b_g6", 32'(grant), 32'h0);
        nxt(); slv(1, 0, 0); ev();
        chk("b_g7", 32'(grant), 32'h1);
        nxt(); mst(0, 0, 0, 0, 0, 0); slv(0, 0, 0); ev();

        // s1 read burst of four while s0 waits
        nxt();
        mst(1, 1, 1, 0, 32'h300, 0);
        mst(0, 1, 1, 0, 32'h400, 0);
        for (int i = 0; i < 4; i++) push(2'b10, 0, 1, 32'hA1 + i);
        push(2'b01, 0, 1, 32'hB0);
        ev();
        chk("c_g0", 32'(grant), 32'h0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            slv(1, 0, 32'hA1 + i);
            ev();
            chk("c_burst_grant", 32'(grant), 32'h2);
        end
        nxt(); mst(1, 0, 0, 0, 0, 0); slv(0, 0, 0); ev();
        chk("c_hold", 32'(grant), 32'h2);
        nxt(); ev();
        chk("c_gap", 32'(grant), 32'h0);
        nxt(); slv(1, 0, 32'hB0); ev();
        chk("c_s0_grant", 32'(grant), 32'h1);
        nxt(); mst(0, 0, 0, 0, 0, 0); slv(0, 0, 0); ev();

        // s0 abandons its cycle mid-strobe; late ack is dropped
        nxt(); mst(0, 1, 1, 0, 32'h500, 0); ev();
        nxt(); ev();
        chk("d_grant", 32'(grant), 32'h1);
        nxt(); mst(0, 0, 0, 0, 0, 0); slv(1, 0, 32'h77); ev();
        chk("d_mcyc", 32'(m_if.cyc), 32'h0);
        chk("d_mstb", 32'(m_if.stb), 32'h0);
        chk("d_late_ack", 32'(s0_if.ack), 32'h0);
        nxt(); slv(0, 0, 0); ev();
        chk("d_idle", 32'(grant), 32'h0);

        // slave never answers: timeout after 8 strobe cycles
        nxt();
        mst(0, 1, 1, 0, 32'h600, 0);
        push(2'b01, 1, 0, 0);
        ev();
        for (int i = 0; i < 8; i++) begin
            nxt(); ev();
            chk("t_wait_stb", 32'(m_if.stb), 32'h1);
            chk("t_wait_tmo", 32'(tmo), 32'h0);
        end
        nxt(); ev();
        chk("t_tmo", 32'(tmo), 32'h1);
        chk("t_err", 32'(s0_if.err), 32'h1);
        chk("t_stb_low", 32'(m_if.stb), 32'h0);
        chk("t_grant", 32'(grant), 32'h1);
        nxt(); mst(0, 0, 0, 0, 0, 0); ev();
        chk("t_tmo_once", 32'(tmo), 32'h0);
        chk("t_hold", 32'(grant), 32'h1);
        nxt(); ev();
        chk("t_idle", 32'(grant), 32'h0);

        // simultaneous ack and err: error wins
        nxt();
        mst(1, 1, 1, 1, 32'h700, 32'h9);
        push(2'b10, 1, 0, 0);
        ev();
        nxt(); slv(1, 1, 0); ev();
        chk("e_ack", 32'(s1_if.ack), 32'h0);
        chk("e_err", 32'(s1_if.err), 32'h1);
        nxt(); mst(1, 0, 0, 0, 0, 0); slv(0, 0, 0); ev();
        nxt(); ev();

        // reset during an s1 strobe, then s0 wins the tie
        nxt(); mst(1, 1, 1, 0, 32'h800, 0); ev();
        nxt(); mst(0, 1, 1, 0, 32'h900, 0); ev();
        chk("f_grant", 32'(grant), 32'h2);
        chk("f_stb", 32'(m_if.stb), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("f_rst_grant", 32'(grant), 32'h0);
        chk("f_rst_mcyc", 32'(m_if.cyc), 32'h0);
        chk("f_rst_mstb", 32'(m_if.stb), 32'h0);
        chk("f_rst_madr", m_if.adr, 32'h0);
        #2;
        rst_n = 1'b1;
        nxt(); ev();
        chk("f_first", 32'(grant), 32'h1);
        chk("f_adr", m_if.adr, 32'h900);
        nxt();
        mst(0, 0, 0, 0, 0, 0);
        mst(1, 0, 0, 0, 0, 0);
        ev();
        nxt(); ev();
        chk("f_idle", 32'(grant), 32'h0);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
